// File: rtl/sevenseg_decode_3_pkg.sv
// Shared definitions for the seven-segment receive decoder: segment bit positions,
// active-low digit enable codes, FSM state type and the segment-to-hex decode table.
// Pure declarations; no logic or latency of its own.
package sevenseg_decode_3_pkg;

   // Bit positions on the 8-bit segment bus (all active low)
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Active-low digit enable codes
   localparam logic [2:0] EN_DIGIT0 = 3'b110;
   localparam logic [2:0] EN_DIGIT1 = 3'b101;
   localparam logic [2:0] EN_DIGIT2 = 3'b011;
   localparam logic [2:0] EN_BLANK  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_HELD  = 2'd2
   } stab_state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] hex;
   } seg_dec_t;

   // Pattern is segments a..g, active low. B and D are indistinguishable from
   // 8 and 0 on a seven-segment display, so those patterns decode as 8 and 0.
   function automatic seg_dec_t decode_pattern(input logic [6:0] pat);
      seg_dec_t r;
      r.valid = 1'b1;
      r.hex   = 4'h0;
      case (pat)
         7'b0000001: r.hex = 4'h0;
         7'b1001111: r.hex = 4'h1;
         7'b0010010: r.hex = 4'h2;
         7'b0000110: r.hex = 4'h3;
         7'b1001100: r.hex = 4'h4;
         7'b0100100: r.hex = 4'h5;
         7'b0100000: r.hex = 4'h6;
         7'b0001111: r.hex = 4'h7;
         7'b0000000: r.hex = 4'h8;
         7'b0000100: r.hex = 4'h9;
         7'b0001000: r.hex = 4'hA;
         7'b0110001: r.hex = 4'hC;
         7'b0110000: r.hex = 4'hE;
         7'b0111000: r.hex = 4'hF;
         default:    r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sevenseg_decode_3_pattern_decode.sv
// Combinational seven-segment pattern decoder (pattern -> valid + hex).
// Latency: zero cycles, purely combinational.
// Backpressure: none.
// Ports: pattern_i segments a..g active low; valid_o pattern is in the table; hex_o decoded value.
module sevenseg_pattern_decode
   import sevenseg_decode_3_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       valid_o,
   output logic [3:0] hex_o
);

   seg_dec_t dec;

   always_comb begin
      dec     = decode_pattern(pattern_i);
      valid_o = dec.valid;
      hex_o   = dec.hex;
   end

endmodule

// File: rtl/sevenseg_decode_3.sv
// Receive-side decoder for a 3-digit multiplexed seven-segment bus: synchronizes,
// debounces each digit pattern and recovers hex value, dp, validity and errors.
// Latency: 2+STABLE_CYCLES cycles from input change to outputs; no backpressure (sampling monitor).
// Ports: clk, rst_n (async active low); SevenSegment/SevenSegmentEnable async active-low bus in;
//        Digit0..2, DigitDp, DigitValid, DigitErr status out; Update, BusErr single-cycle pulses.
module sevenseg_decode_3
   import sevenseg_decode_3_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] SevenSegment,
   input  logic [2:0] SevenSegmentEnable,
   output logic [3:0] Digit0,
   output logic [3:0] Digit1,
   output logic [3:0] Digit2,
   output logic [2:0] DigitDp,
   output logic [2:0] DigitValid,
   output logic [2:0] DigitErr,
   output logic       Update,
   output logic       BusErr
);

   localparam logic [7:0]  STABLE_TGT = 8'(STABLE_CYCLES);
   localparam logic [23:0] TMO_RELOAD = 24'(TIMEOUT_CYCLES);

   // Two-flop synchronizers; reset to all-ones (blank, all segments off)
   logic [7:0] seg_s1_q, seg_s2_q;
   logic [2:0] en_s1_q, en_s2_q;

   // Stability tracker
   stab_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [10:0] samp_q, samp_d;    // {enable, segments} currently being tracked
   logic [10:0] cur_samp;
   logic        accept;

   // Per-digit output state
   logic [3:0]  digit_q [3];
   logic [3:0]  digit_d [3];
   logic [23:0] tmo_q   [3];
   logic [23:0] tmo_d   [3];
   logic [2:0]  dp_q, dp_d;
   logic [2:0]  valid_q, valid_d;
   logic [2:0]  err_q, err_d;
   logic        upd_q, upd_d;
   logic        buserr_q, buserr_d;

   // Accepted-pattern decode
   logic [2:0]  acc_en;
   logic        acc_dp;
   logic        acc_onehot;
   logic [2:0]  digit_hit;
   logic        dec_valid;
   logic [3:0]  dec_hex;

   assign cur_samp = {en_s2_q, seg_s2_q};

   // Stability FSM: a pattern is accepted once, on the cycle its run of identical
   // samples reaches STABLE_CYCLES; HELD then suppresses re-acceptance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      samp_d  = samp_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_s2_q != EN_BLANK) begin
               state_d = ST_TRACK;
               cnt_d   = 8'd1;
               samp_d  = cur_samp;
            end
         end
         ST_TRACK: begin
            if (en_s2_q == EN_BLANK) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else if (cur_samp == samp_q) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == STABLE_TGT) begin
                  accept  = 1'b1;
                  state_d = ST_HELD;
               end
            end else begin
               cnt_d  = 8'd1;
               samp_d = cur_samp;
            end
         end
         ST_HELD: begin
            if (en_s2_q == EN_BLANK) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else if (cur_samp != samp_q) begin
               state_d = ST_TRACK;
               cnt_d   = 8'd1;
               samp_d  = cur_samp;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // On accept, samp_q equals the current sample, so decode the registered copy.
   assign acc_en     = samp_q[10:8];
   assign acc_dp     = ~samp_q[SEG_DP];
   assign acc_onehot = (acc_en == EN_DIGIT0) || (acc_en == EN_DIGIT1) || (acc_en == EN_DIGIT2);
   assign digit_hit  = (accept && acc_onehot) ? ~acc_en : 3'b000;

   sevenseg_pattern_decode u_pattern_decode (
      .pattern_i (samp_q[SEG_A:SEG_G]),
      .valid_o   (dec_valid),
      .hex_o     (dec_hex)
   );

   always_comb begin
      dp_d     = dp_q;
      valid_d  = valid_q;
      err_d    = err_q;
      upd_d    = 1'b0;
      buserr_d = accept && !acc_onehot;
      for (int i = 0; i < 3; i++) begin
         digit_d[i] = digit_q[i];
         tmo_d[i]   = tmo_q[i];
         // Valid drops on the cycle the counter reaches zero, and stays low there.
         if (tmo_q[i] != 24'd0) tmo_d[i] = tmo_q[i] - 24'd1;
         if (tmo_q[i] <= 24'd1) valid_d[i] = 1'b0;
         // Accept is applied last so it overrides a coincident timeout.
         if (digit_hit[i]) begin
            tmo_d[i] = TMO_RELOAD;
            if (dec_valid) begin
               if ((digit_q[i] != dec_hex) || (dp_q[i] != acc_dp)) upd_d = 1'b1;
               digit_d[i] = dec_hex;
               dp_d[i]    = acc_dp;
               valid_d[i] = 1'b1;
               err_d[i]   = 1'b0;
            end else begin
               err_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q <= '1;
         seg_s2_q <= '1;
         en_s1_q  <= '1;
         en_s2_q  <= '1;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         samp_q   <= '1;
         for (int i = 0; i < 3; i++) begin
            digit_q[i] <= '0;
            tmo_q[i]   <= '0;
         end
         dp_q     <= '0;
         valid_q  <= '0;
         err_q    <= '0;
         upd_q    <= 1'b0;
         buserr_q <= 1'b0;
      end else begin
         seg_s1_q <= SevenSegment;
         seg_s2_q <= seg_s1_q;
         en_s1_q  <= SevenSegmentEnable;
         en_s2_q  <= en_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         samp_q   <= samp_d;
         for (int i = 0; i < 3; i++) begin
            digit_q[i] <= digit_d[i];
            tmo_q[i]   <= tmo_d[i];
         end
         dp_q     <= dp_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         upd_q    <= upd_d;
         buserr_q <= buserr_d;
      end
   end

   assign Digit0     = digit_q[0];
   assign Digit1     = digit_q[1];
   assign Digit2     = digit_q[2];
   assign DigitDp    = dp_q;
   assign DigitValid = valid_q;
   assign DigitErr   = err_q;
   assign Update     = upd_q;
   assign BusErr     = buserr_q;

endmodule

// File: tb/tb_sevenseg_decode_3.sv
module tb_sevenseg_decode_3;

   localparam int STABLE = 4;
   localparam int TMO    = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] SevenSegment = 8'hFF;
   logic [2:0] SevenSegmentEnable = 3'b111;
   logic [3:0] Digit0, Digit1, Digit2;
   logic [2:0] DigitDp, DigitValid, DigitErr;
   logic       Update, BusErr;

   int total = 0;
   int passed = 0;
   int upd_seen = 0;
   int bus_seen = 0;

   always #5 clk = ~clk;

   sevenseg_decode_3 #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .SevenSegment       (SevenSegment),
      .SevenSegmentEnable (SevenSegmentEnable),
      .Digit0             (Digit0),
      .Digit1             (Digit1),
      .Digit2             (Digit2),
      .DigitDp            (DigitDp),
      .DigitValid         (DigitValid),
      .DigitErr           (DigitErr),
      .Update             (Update),
      .BusErr             (BusErr)
   );

   // ---------------- reference model ----------------
   logic [6:0] pat_tab [14] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b0110001,
                                7'b0110000, 7'b0111000};
   logic [3:0] hex_tab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h8, 4'h9, 4'hA, 4'hC, 4'hE, 4'hF};

   logic [10:0] m_pipe1, m_pipe2, m_prev, m_s;
   int          m_run;
   int          m_rem [3];
   logic [3:0]  e_dig [3];
   logic [2:0]  e_dp, e_val, e_err;
   logic        e_upd, e_bus;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pipe1 = '1; m_pipe2 = '1; m_prev = '1; m_run = 0;
         for (int i = 0; i < 3; i++) begin m_rem[i] = 0; e_dig[i] = 4'h0; end
         e_dp = 3'b000; e_val = 3'b000; e_err = 3'b000; e_upd = 1'b0; e_bus = 1'b0;
      end else begin
         int   nlow, d, hit;
         logic dp;
         m_s = m_pipe2;
         m_pipe2 = m_pipe1;
         m_pipe1 = {SevenSegmentEnable, SevenSegment};
         e_upd = 1'b0;
         e_bus = 1'b0;
         // run length of identical non-blank samples
         if (m_s[10:8] == 3'b111) m_run = 0;
         else if (m_run > 0 && m_s == m_prev) begin if (m_run < 1000) m_run++; end
         else m_run = 1;
         m_prev = m_s;
         for (int i = 0; i < 3; i++) begin
            if (m_rem[i] > 0) m_rem[i]--;
            if (m_rem[i] == 0) e_val[i] = 1'b0;
         end
         if (m_run == STABLE) begin
            nlow = (m_s[8] ? 0 : 1) + (m_s[9] ? 0 : 1) + (m_s[10] ? 0 : 1);
            if (nlow >= 2) e_bus = 1'b1;
            else begin
               d = !m_s[8] ? 0 : (!m_s[9] ? 1 : 2);
               m_rem[d] = TMO;
               dp = ~m_s[0];
               hit = -1;
               for (int k = 0; k < 14; k++) if (pat_tab[k] == m_s[7:1]) hit = k;
               if (hit >= 0) begin
                  if (e_dig[d] != hex_tab[hit] || e_dp[d] != dp) e_upd = 1'b1;
                  e_dig[d] = hex_tab[hit];
                  e_dp[d] = dp;
                  e_val[d] = 1'b1;
                  e_err[d] = 1'b0;
               end else e_err[d] = 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk();
      if (Update === 1'b1) upd_seen++;
      if (BusErr === 1'b1) bus_seen++;
      cmp("digit0", 32'(Digit0), 32'(e_dig[0]));
      cmp("digit1", 32'(Digit1), 32'(e_dig[1]));
      cmp("digit2", 32'(Digit2), 32'(e_dig[2]));
      cmp("dp",     32'(DigitDp), 32'(e_dp));
      cmp("valid",  32'(DigitValid), 32'(e_val));
      cmp("err",    32'(DigitErr), 32'(e_err));
      cmp("update", 32'(Update), 32'(e_upd));
      cmp("buserr", 32'(BusErr), 32'(e_bus));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         chk();
      end
   endtask

   // Number of cycles until the first Update pulse, 0 if none within 20.
   task automatic wait_update(output int k);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (Update === 1'b1) begin k = i; break; end
      end
   endtask

   task automatic drive(input logic [2:0] en, input logic [7:0] seg);
      SevenSegmentEnable = en;
      SevenSegment = seg;
   endtask

   initial begin
      int k;
      logic [2:0] en;
      logic [7:0] seg;
      logic [2:0] en_tab [6] = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b100, 3'b000};

      // reset state
      #12;
      cmp("rst_digit0", 32'(Digit0), 32'h0);
      cmp("rst_dp", 32'(DigitDp), 32'h0);
      cmp("rst_valid", 32'(DigitValid), 32'h0);
      cmp("rst_err", 32'(DigitErr), 32'h0);
      cmp("rst_pulses", 32'({Update, BusErr}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(2);

      // steady digit0 = 2 with dp lit: single Update six cycles after change
      drive(3'b110, 8'b00100100);
      upd_seen = 0;
      wait_update(k);
      cmp("hold_latency", 32'(k), 32'd6);
      cyc(20 - k);
      cmp("hold_digit0", 32'(Digit0), 32'h2);
      cmp("hold_dp", 32'(DigitDp), 32'b001);
      cmp("hold_valid", 32'(DigitValid), 32'b001);
      cmp("hold_updates", 32'(upd_seen), 32'd1);

      // scan 9 / 1 / F across the three digits, then rescan identical values
      upd_seen = 0;
      drive(3'b110, 8'b00001001); cyc(8);
      drive(3'b101, 8'b10011111); cyc(8);
      drive(3'b011, 8'b01110001); cyc(8);
      cmp("scan_updates", 32'(upd_seen), 32'd3);
      upd_seen = 0;
      drive(3'b110, 8'b00001001); cyc(8);
      drive(3'b101, 8'b10011111); cyc(8);
      drive(3'b011, 8'b01110001); cyc(8);
      cmp("rescan_updates", 32'(upd_seen), 32'd0);
      cmp("scan_digits", 32'({Digit2, Digit1, Digit0}), 32'hF19);
      cmp("scan_valid", 32'(DigitValid), 32'b111);

      // pattern toggling faster than the stability window is never accepted
      upd_seen = 0;
      for (int i = 0; i < 6; i++) begin
         drive(3'b101, (i % 2 == 0) ? 8'b00001101 : 8'b10011001);
         cyc(3);
      end
      cmp("glitch_digit1", 32'(Digit1), 32'h1);
      cmp("glitch_valid1", 32'(DigitValid[1]), 32'h1);
      cmp("glitch_updates", 32'(upd_seen), 32'd0);

      // undecodable pattern on digit2, then a valid 7 clears the error
      drive(3'b011, 8'b11111110); cyc(8);
      cmp("inv_err", 32'(DigitErr), 32'b100);
      cmp("inv_digit2", 32'(Digit2), 32'hF);
      drive(3'b011, 8'b00011111); cyc(8);
      cmp("fix_err", 32'(DigitErr), 32'b000);
      cmp("fix_digit2", 32'(Digit2), 32'h7);

      // two enables low: one BusErr pulse, digits untouched
      bus_seen = 0;
      drive(3'b100, 8'b00000001); cyc(8);
      cmp("bus_pulses", 32'(bus_seen), 32'd1);
      cmp("bus_digits", 32'({Digit2, Digit1, Digit0}), 32'h719);

      // stop refreshing: all valid bits time out, values retained
      drive(3'b111, 8'hFF); cyc(TMO + 10);
      cmp("tmo_valid", 32'(DigitValid), 32'b000);
      cmp("tmo_digits", 32'({Digit2, Digit1, Digit0}), 32'h719);

      // reset while tracking digit1, then full latency after release
      drive(3'b101, 8'b00001101); cyc(4);
      #1 rst_n = 1'b0;
      #1;
      cmp("arst_digits", 32'({Digit2, Digit1, Digit0}), 32'h0);
      cmp("arst_flags", 32'({DigitDp, DigitValid, DigitErr}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_update(k);
      cmp("arst_latency", 32'(k), 32'(2 + STABLE));
      cmp("arst_digit1", 32'(Digit1), 32'h3);
      cyc(4);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         en = en_tab[($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5)];
         if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
         else seg = {pat_tab[$urandom_range(0, 13)], 1'($urandom)};
         drive(en, seg);
         cyc($urandom_range(1, 8));
      end
      drive(3'b111, 8'hFF);
      cyc(TMO + 5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sevenseg_decode_3.md
# sevenseg_decode_3

Receive-side decoder for the 3-digit multiplexed seven-segment display bus. It samples the segment/enable bus driven by a display source (on-board or an external pin header), waits for each digit pattern to hold steady, and recovers the displayed hex value, decimal point and validity per digit. It sits between the display pins and monitoring/self-check logic, the inverse of the hex-to-segment encoders.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted (2..255).
- TIMEOUT_CYCLES, 1000000: cycles without an accepted refresh before a digit's valid bit clears (fits 24 bits).
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- SevenSegment  input  8  segment bus, active low, bit7..bit1 = a,b,c,d,e,f,g, bit0 = dp; asynchronous to clk.
- SevenSegmentEnable  input  3  digit enables, active low one-hot (110 = digit0, 101 = digit1, 011 = digit2); asynchronous.
- Digit0, Digit1, Digit2  output  4 each  last accepted hex value per digit.
- DigitDp  output  3  last accepted dp per digit, active high (1 = lit).
- DigitValid  output  3  digit accepted and refreshed within TIMEOUT_CYCLES.
- DigitErr  output  3  last stable pattern on that digit was not in the decode table (sticky until next valid accept).
- Update  output  1  one-cycle pulse when any Digit/DigitDp value changes.
- BusErr  output  1  one-cycle pulse per accepted sample window with two or more enables low.

## Operation
- Both buses pass through a 2-flop synchronizer; decoding uses the second flop only.
- Decode table on bits 7..1 (active low): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 0110001→C, 0110000→E, 0111000→F. B and D share the patterns of 8 and 0 and decode as 8 and 0. All other patterns are invalid.
- Stability FSM, states IDLE, TRACK, HELD:
  - IDLE: enable 111 (blank). Any other enable → TRACK, count=1.
  - TRACK: sample equal to previous → count+1; differs → count=1 (stay TRACK, or IDLE if blank). count reaching STABLE_CYCLES → accept, go HELD.
  - HELD: sample equal → stay (no re-accept, no count growth); differs → TRACK count=1 or IDLE.
- Accept with one-hot enable and valid pattern: write Digit/DigitDp for that digit, set DigitValid, clear DigitErr, reload that digit's timeout counter; Update pulses only if value or dp changed.
- Accept with one-hot enable and invalid pattern: set DigitErr, leave Digit/DigitDp, reload timeout counter.
- Accept with multiple enables low: pulse BusErr, no digit touched.
- Per-digit timeout counter decrements each cycle; at zero DigitValid clears (Digit retains value); counter holds at zero.

## Timing
- Reset values: Digit0..2=0, DigitDp=000, DigitValid=000, DigitErr=000, Update=0, BusErr=0, FSM=IDLE, synchronizers=all-ones, timeout counters=0.
- Input change settling at cycle N: first synchronized sample at N+2 (count=1), accept at N+1+STABLE_CYCLES, outputs and Update/BusErr visible at N+2+STABLE_CYCLES.
- Glitch shorter than STABLE_CYCLES samples never accepted.
- Timeout: DigitValid clears TIMEOUT_CYCLES cycles after the accept that last reloaded it.
- Accept and timeout on the same digit in the same cycle: accept wins.
- rst_n assertion mid-TRACK or mid-HELD: all outputs to reset values immediately; after deassertion FSM restarts from IDLE.

## Structure
- Shared package: segment bit-position constants, enable codes (110/101/011/111), decode table as a function returning {valid, hex}.
- One sub-module: sevenseg_pattern_decode (combinational 7-bit pattern → valid + 4-bit hex), reusable by other monitors.
- Top holds synchronizer, stability FSM, three timeout counters, output registers.

## Test plan
- Hold enable 110, segments 00100100 steady 20 cycles → Digit0=2, DigitDp=001, DigitValid=001, single Update at cycle 6 after change.
- Scan digits 110/101/011 with 0x9,0x1,0xF, 8 cycles each → Digit0=9, Digit1=1, Digit2=F, DigitValid=111, three Update pulses, rescanning same values gives no further Update.
- Enable 101 with segments toggling between 3 and 4 every 3 cycles → no accept; Digit1, DigitValid[1] unchanged.
- Enable 011, pattern 11111110 (only dp) for 8 cycles → DigitErr[2]=1, Digit2 unchanged; then valid 0x7 → DigitErr[2]=0, Digit2=7.
- Enable 100 for 8 cycles → one BusErr pulse, no digit change; TIMEOUT_CYCLES=50, stop refreshing digit0 → DigitValid[0] clears 50 cycles after last accept.
- Assert rst_n low during TRACK on digit1 → all outputs zero asynchronously; after release, same stable input accepted after full 2+STABLE_CYCLES latency.
